// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU-wide scalar types.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage
`default_nettype wire

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Types shared by the fetch queue unit and its FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;
endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_unit_if
//  Description : Instruction-cache request/response bundle seen by the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_unit_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    modport master (output imemREN, output imemaddr, input ihit, input imemload);
    modport slave  (input imemREN, input imemaddr, output ihit, output imemload);
endinterface
`default_nettype wire

// File: rtl/fetch_queue_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH-entry first-word-fall-through queue of fetch entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                       CLK,
    input  wire logic                       RST,
    input  wire logic                       push,
    input  wire fetch_entry_t               push_data,
    input  wire logic                       pop,
    input  wire logic                       clear,
    output fetch_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_head];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage has no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge CLK) begin
        if (w_push && !clear) r_mem[r_tail] <= push_data;
    end
endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_unit
//  Description : Instruction fetch stage with a decoupling prefetch queue.
//                Optional FETCH_QUEUE_PERF_EN adds fetched/flushed counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
    import cpu_types_pkg::*;
    import fetch_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] PC_INIT     = 32'h0,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  wire logic                       CLK,
    input  wire logic                       RST,
    fetch_queue_unit_if.master              icache,
    input  wire logic                       redirect,
    input  wire word_t                      redirect_pc,
    input  wire logic                       dq_ready,
    output logic                            dq_valid,
    output word_t                           dq_instr,
    output word_t                           dq_pc,
    output word_t                           dq_pc4,
    output logic [$clog2(DEPTH+1)-1:0]      count,
`ifdef FETCH_QUEUE_PERF_EN
    output word_t                           perf_fetched,
    output word_t                           perf_flushed,
`endif
    output logic                            halted
);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_state_t       r_state;
    word_t              r_fetch_pc;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_data;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_is_halt;

    assign icache.imemREN  = ~RST & (r_state == FETCH) & ~w_full;
    assign icache.imemaddr = r_fetch_pc;

    assign w_is_halt   = (icache.imemload[31:26] == HALT_OPCODE);
    assign w_push      = icache.imemREN & icache.ihit & ~redirect;
    assign w_pop       = dq_valid & dq_ready;
    assign w_push_data = '{instr: icache.imemload, pc: r_fetch_pc};

    assign dq_valid = ~w_empty & ~redirect;
    assign dq_instr = w_empty ? 32'h0 : w_head.instr;
    assign dq_pc    = w_empty ? 32'h0 : w_head.pc;
    assign dq_pc4   = dq_pc + 32'd4;
    assign halted   = (r_state == HALTED) & w_empty;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .clear     (redirect),
        .head      (w_head),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Redirect reopens fetching even from HALTED: the queued HALT may be wrong-path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_pc <= PC_INIT;
            r_state    <= FETCH;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            r_state    <= FETCH;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_is_halt) r_state <= HALTED;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    word_t          r_fetched;
    word_t          r_flushed;
    logic [32:0]    w_flush_sum;

    assign w_flush_sum = {1'b0, r_flushed} + 33'(count)
                       + 33'(icache.imemREN & icache.ihit);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetched <= '0;
            r_flushed <= '0;
        end else begin
            if (w_push && r_fetched != 32'hFFFF_FFFF) r_fetched <= r_fetched + 32'd1;
            if (redirect) r_flushed <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
        end
    end

    assign perf_fetched = r_fetched;
    assign perf_flushed = r_flushed;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue_unit
//  Description : Directed self-checking bench for fetch_queue_unit (DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        redirect;
    word_t       redirect_pc;
    logic        dq_ready;
    logic        dq_valid;
    word_t       dq_instr;
    word_t       dq_pc;
    word_t       dq_pc4;
    logic [2:0]  count;
    logic        halted;
    word_t       perf_fetched;
    word_t       perf_flushed;
    logic        halt_en;
    word_t       halt_addr;
    int          tests;
    int          failed;

    fetch_queue_unit_if bus ();

    always #5 CLK = ~CLK;

    // Cache model: every word encodes its own address; one address may return HALT.
    assign bus.imemload = (halt_en && bus.imemaddr == halt_addr) ? 32'hFC00_0000
                                                                 : {6'h01, bus.imemaddr[25:0]};

    fetch_queue_unit #(.DEPTH(4), .PC_INIT(32'h0), .HALT_OPCODE(6'h3F)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .icache       (bus.master),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .dq_ready     (dq_ready),
        .dq_valid     (dq_valid),
        .dq_instr     (dq_instr),
        .dq_pc        (dq_pc),
        .dq_pc4       (dq_pc4),
        .count        (count),
`ifdef FETCH_QUEUE_PERF_EN
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed),
`endif
        .halted       (halted)
    );

`ifndef FETCH_QUEUE_PERF_EN
    assign perf_fetched = 32'h0;
    assign perf_flushed = 32'h0;
`endif

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; dq_ready = 1'b0; bus.ihit = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; dq_ready = 1'b0; bus.ihit = 1'b0;
        tick();
        tick();
        tests++; if (bus.imemREN !== 1'b0) begin failed++; $display("FAIL reset_imemREN got=%b exp=0", bus.imemREN); end
        tests++; if (dq_valid !== 1'b0) begin failed++; $display("FAIL reset_dq_valid got=%b exp=0", dq_valid); end
        tests++; if (count !== 3'd0) begin failed++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (dq_instr !== 32'h0) begin failed++; $display("FAIL reset_dq_instr got=%h exp=0", dq_instr); end
        tests++; if (dq_pc4 !== 32'h4) begin failed++; $display("FAIL reset_dq_pc4 got=%h exp=4", dq_pc4); end
        tests++; if (halted !== 1'b0) begin failed++; $display("FAIL reset_halted got=%b exp=0", halted); end
        RST = 1'b0;
        #1;
        tests++; if (bus.imemREN !== 1'b1) begin failed++; $display("FAIL release_imemREN got=%b exp=1", bus.imemREN); end
        tests++; if (bus.imemaddr !== 32'h0) begin failed++; $display("FAIL release_imemaddr got=%h exp=0", bus.imemaddr); end
    endtask

    task automatic test_fill();
        do_reset();
        bus.ihit = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++; if (count !== 3'(i)) begin failed++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
        end
        tests++; if (bus.imemREN !== 1'b0) begin failed++; $display("FAIL fill_imemREN got=%b exp=0", bus.imemREN); end
        tests++; if (bus.imemaddr !== 32'h10) begin failed++; $display("FAIL fill_imemaddr got=%h exp=10", bus.imemaddr); end
        tests++; if (dq_instr !== 32'h0400_0000) begin failed++; $display("FAIL fill_head_instr got=%h exp=04000000", dq_instr); end
        tick();
        tests++; if (count !== 3'd4) begin failed++; $display("FAIL full_hold_count got=%0d exp=4", count); end
        tests++; if (bus.imemaddr !== 32'h10) begin failed++; $display("FAIL full_hold_addr got=%h exp=10", bus.imemaddr); end
        // One pop frees a slot; the request comes back on the following cycle.
        dq_ready = 1'b1;
        tick();
        dq_ready = 1'b0;
        #1;
        tests++; if (count !== 3'd3 || bus.imemREN !== 1'b1) begin failed++; $display("FAIL pop_reopen count=%0d ren=%b exp count=3 ren=1", count, bus.imemREN); end
        bus.ihit = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        bus.ihit = 1'b1;
        dq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++; if (dq_valid !== 1'b1 || dq_pc !== 32'(4*i)) begin failed++; $display("FAIL stream_pc[%0d] got=%h valid=%b exp=%h", i, dq_pc, dq_valid, 32'(4*i)); end
            tests++; if (count !== 3'd1) begin failed++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
        end
        tests++; if (dq_pc4 !== 32'd24) begin failed++; $display("FAIL stream_pc4 got=%h exp=18", dq_pc4); end
        bus.ihit = 1'b0; dq_ready = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        bus.ihit = 1'b1;
        tick(); tick(); tick();
        tests++; if (count !== 3'd3) begin failed++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
        redirect = 1'b1; redirect_pc = 32'h43;
        #1;
        tests++; if (dq_valid !== 1'b0) begin failed++; $display("FAIL redir_valid_forced got=%b exp=0", dq_valid); end
        tick();
        redirect = 1'b0; bus.ihit = 1'b0;
        #1;
        tests++; if (count !== 3'd0) begin failed++; $display("FAIL redir_count got=%0d exp=0", count); end
        tests++; if (bus.imemaddr !== 32'h40) begin failed++; $display("FAIL redir_addr got=%h exp=40", bus.imemaddr); end
`ifdef FETCH_QUEUE_PERF_EN
        tests++; if (perf_flushed !== 32'd4) begin failed++; $display("FAIL perf_flushed got=%0d exp=4", perf_flushed); end
        tests++; if (perf_fetched !== 32'd3) begin failed++; $display("FAIL perf_fetched got=%0d exp=3", perf_fetched); end
`endif
        bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        #1;
        tests++; if (dq_pc !== 32'h40 || dq_instr !== 32'h0400_0040) begin failed++; $display("FAIL redir_head pc=%h instr=%h exp pc=40 instr=04000040", dq_pc, dq_instr); end
    endtask

    task automatic test_halt();
        do_reset();
        halt_en = 1'b1; halt_addr = 32'h8;
        bus.ihit = 1'b1;
        tick(); tick(); tick();
        tests++; if (bus.imemREN !== 1'b0) begin failed++; $display("FAIL halt_imemREN got=%b exp=0", bus.imemREN); end
        tests++; if (count !== 3'd3 || halted !== 1'b0) begin failed++; $display("FAIL halt_pending count=%0d halted=%b exp count=3 halted=0", count, halted); end
        dq_ready = 1'b1;
        tick(); tick();
        tests++; if (dq_instr !== 32'hFC00_0000 || halted !== 1'b0) begin failed++; $display("FAIL halt_head instr=%h halted=%b exp instr=fc000000 halted=0", dq_instr, halted); end
        tick();
        tests++; if (halted !== 1'b1 || bus.imemREN !== 1'b0) begin failed++; $display("FAIL halt_drained halted=%b ren=%b exp halted=1 ren=0", halted, bus.imemREN); end
        dq_ready = 1'b0; bus.ihit = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        #1;
        tests++; if (bus.imemREN !== 1'b1 || bus.imemaddr !== 32'h20 || halted !== 1'b0) begin failed++; $display("FAIL halt_resume ren=%b addr=%h halted=%b exp ren=1 addr=20 halted=0", bus.imemREN, bus.imemaddr, halted); end
        halt_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] ready_pat;
        logic [15:0] hit_pat;
        word_t       exp_pc;
        int          pops;
        logic        bad;
        ready_pat = 16'b1011_0010_1110_0110;
        hit_pat   = 16'b1110_1111_0110_1111;
        exp_pc = 32'h0; pops = 0; bad = 1'b0;
        do_reset();
        for (int i = 0; i < 200 && pops < 12; i++) begin
            dq_ready = ready_pat[i % 16];
            bus.ihit = hit_pat[(i * 3) % 16];
            #1;
            if (dq_valid && dq_ready) begin
                tests++;
                if (dq_pc !== exp_pc || dq_instr !== {6'h01, exp_pc[25:0]}) begin
                    failed++; bad = 1'b1;
                    $display("FAIL wrap_pc[%0d] got=%h exp=%h", pops, dq_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (count > 3'd4 && !bad) begin
                failed++; bad = 1'b1;
                $display("FAIL wrap_count got=%0d exp<=4", count);
            end
            tick();
        end
        tests++; if (pops !== 12) begin failed++; $display("FAIL wrap_pops got=%0d exp=12", pops); end
        dq_ready = 1'b0; bus.ihit = 1'b0;
    endtask

    initial begin
        tests = 0; failed = 0;
        halt_en = 1'b0; halt_addr = 32'h0;
        bus.ihit = 1'b0;
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_halt();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
`default_nettype wire
